mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit 4:1 multiplexer datapath between four requesters. It owns the mux select, runs a valid/ready handshake to a single downstream consumer, and returns a per-requester acknowledge on each accepted beat. A requester may hold the grant for up to BURST consecutive beats before priority rotates. It sits between four producer blocks and a shared sink such as a bus, a FIFO write port or a serializer.

Parameters:
WIDTH, 8, data width of each requester and of the output.
BURST, 1, maximum beats per grant; legal range 1..15.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
req  input  4  per-requester request; held with data until acked.
din0  input  WIDTH  requester 0 data.
din1  input  WIDTH  requester 1 data.
din2  input  WIDTH  requester 2 data.
din3  input  WIDTH  requester 3 data.
out_ready  input  1  downstream accepts the beat when high with out_valid.
out_valid  output  1  out_data is valid.
out_data  output  WIDTH  selected requester data.
sel  output  2  registered mux select, i.e. the granted index.
grant  output  4  one-hot registered grant; 0 in IDLE.
ack  output  4  one-hot, combinational: ack[sel] = out_valid & out_ready.
busy  output  1  high in the GRANT state.

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, grant=0, last=3 (so requester 0 has top priority first), beat_cnt=0. Combinationally this gives out_valid=0, ack=0 and busy=0. out_data then follows din0.
- States: IDLE, GRANT. The state, sel, grant, last and beat_cnt are registered.
- Priority: search order is last+1, last+2, last+3, last (all mod 4). The first requester found with req high wins.
- IDLE: if any req bit is high at a clock edge, move to GRANT with sel=winner and grant=onehot(winner). The arbitration latency is one cycle from req rising to out_valid.
- GRANT:
  - out_valid = req[sel].
  - out_data = din[sel] through a combinational mux.
  - A beat is accepted when out_valid & out_ready. On acceptance, beat_cnt increments.
- Release from GRANT happens at the edge when either condition holds:
  - a beat is accepted and beat_cnt+1 == BURST, or
  - req[sel] == 0 (withdrawal; no beat, no ack).
- On release:
  - last <= sel and beat_cnt <= 0.
  - Re-arbitrate in the same cycle using the search order starting at sel+1 and the current req, with req[sel] masked on a withdrawal.
  - If a winner exists, stay in GRANT with the new sel and grant. There is no idle bubble, so back-to-back beats are allowed.
  - Otherwise go to IDLE.
- Backpressure: while out_valid & !out_ready, sel, grant and beat_cnt hold. out_data is stable provided the requester holds din.
- Protocol rule: a requester keeps req high and din stable until it sees its ack. Dropping req early is a withdrawal, not an error.
- Simultaneous events:
  - A newly arriving req never preempts an active grant.
  - If the granted requester re-requests on its final beat, it is considered last in the rotation.
- Single requester: it is regranted every BURST beats with no gap.
- Reset mid-transfer: all state is lost, no ack is issued, and the cycle is not completed.
- beat_cnt is 4 bits wide and cannot overflow for legal BURST values.

Decomposition:
- A shared package or header holds:
  - the state encoding (IDLE=0, GRANT=1),
  - the PTR_W=2 pointer width,
  - the rr_pick function (a 4-bit req plus a 2-bit start index returns a valid flag and an index).
- Sub-module mux4_bus is the WIDTH-wide combinational 4:1 data mux driven by sel. It has no other logic.

Test Plan:
1. Reset release, BURST=1, req=4'b0101 held, out_ready=1:
   - grant sequence 0001, 0100, 0001, 0100 on consecutive cycles.
   - sel=00, 10, 00, 10.
   - first out_valid occurs one cycle after req is seen.
2. BURST=1, only req[1]=1, din1=8'hA5, out_ready low for 3 cycles:
   - out_valid=1, out_data=8'hA5 and grant=0010 are stable.
   - ack=0 during those cycles.
   - ack=0010 in the cycle out_ready rises.
3. BURST=2, req=4'b1111 held, out_ready=1:
   - acks arrive in order 0,0,1,1,2,2,3,3,0, with no idle cycle between beats.
4. Granted requester 2 drops req before ready (withdrawal) while req[3] is high:
   - no ack[2].
   - next cycle grant=1000 and sel=11.
5. Assert rst while GRANT with out_valid=1:
   - out_valid, grant, ack and busy drop to 0 without waiting for clk.
   - after rst releases with only req[3] high, grant=1000 at the next edge.
6. BURST=3, req=4'b0001 only:
   - continuous acks on ack[0] every cycle.
   - beat_cnt wraps 0,1,2,0 and busy stays high.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// pointer width and the rotating priority search.
package mux4_rr_arbiter_pkg;

  localparam int PTR_W = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef struct packed {
    logic             vld;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // The first requester found at start, start+1, start+2, start+3 (mod 4) wins.
  // The scan runs from the farthest offset down, so the nearest hit overwrites.
  function automatic rr_pick_t rr_pick(input logic [3:0] req, input logic [PTR_W-1:0] start);
    rr_pick_t         r;
    logic [PTR_W-1:0] k;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      k = start + PTR_W'(i);
      if (req[k]) begin
        r.vld = 1'b1;
        r.idx = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_bus.sv
// WIDTH-wide combinational 4:1 data mux steered by the arbiter select.
module mux4_bus
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [PTR_W-1:0] i_sel,
  input  logic [WIDTH-1:0] i_din0,
  input  logic [WIDTH-1:0] i_din1,
  input  logic [WIDTH-1:0] i_din2,
  input  logic [WIDTH-1:0] i_din3,
  output logic [WIDTH-1:0] o_dout
);

  always_comb begin
    case (i_sel)
      2'd0:    o_dout = i_din0;
      2'd1:    o_dout = i_din1;
      2'd2:    o_dout = i_din2;
      default: o_dout = i_din3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters, with a
// valid/ready output handshake and up to BURST beats per grant.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [PTR_W-1:0] sel,
  output logic [3:0]       grant,
  output logic [3:0]       ack,
  output logic             busy
);

  logic [0:0]       r_state;
  logic [PTR_W-1:0] r_sel;
  logic [3:0]       r_grant;
  logic [PTR_W-1:0] r_last;
  logic [3:0]       r_beat_cnt;

  logic             w_busy;
  logic [3:0]       w_sel_oh;
  logic             w_accept;
  logic [3:0]       w_beat_nxt;
  logic             w_final;
  logic             w_withdraw;
  logic             w_release;
  logic [3:0]       w_req_arb;
  logic [PTR_W-1:0] w_start;
  rr_pick_t         w_pick;

  assign w_busy     = (r_state == ST_GRANT);
  assign w_sel_oh   = 4'b0001 << r_sel;
  assign out_valid  = w_busy & req[r_sel];
  assign w_accept   = out_valid & out_ready;
  assign w_beat_nxt = r_beat_cnt + 4'd1;
  assign w_final    = w_accept && (w_beat_nxt == 4'(BURST));
  assign w_withdraw = w_busy & ~req[r_sel];
  assign w_release  = w_final | w_withdraw;

  // Starting the search just past the current owner puts it last in line,
  // so a requester re-asserting on its final beat only wins if nobody else asks.
  assign w_req_arb  = w_withdraw ? (req & ~w_sel_oh) : req;
  assign w_start    = w_busy ? (r_sel + 2'd1) : (r_last + 2'd1);
  assign w_pick     = rr_pick(w_req_arb, w_start);

  assign ack   = w_accept ? w_sel_oh : 4'b0000;
  assign sel   = r_sel;
  assign grant = r_grant;
  assign busy  = w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_grant    <= '0;
      r_last     <= 2'd3;
      r_beat_cnt <= '0;
    end else if (!w_busy) begin
      if (w_pick.vld) begin
        r_state <= ST_GRANT;
        r_sel   <= w_pick.idx;
        r_grant <= 4'b0001 << w_pick.idx;
      end
    end else if (w_release) begin
      r_last     <= r_sel;
      r_beat_cnt <= '0;
      if (w_pick.vld) begin
        r_sel   <= w_pick.idx;
        r_grant <= 4'b0001 << w_pick.idx;
      end else begin
        r_state <= ST_IDLE;
        r_grant <= '0;
      end
    end else if (w_accept) begin
      r_beat_cnt <= w_beat_nxt;
    end
  end

  mux4_bus #(.WIDTH(WIDTH)) u_bus (
    .i_sel  (r_sel),
    .i_din0 (din0),
    .i_din1 (din1),
    .i_din2 (din2),
    .i_din3 (din3),
    .o_dout (out_data)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: three instances with BURST=1,2,3,
// expected outputs queued at drive time and compared mid-cycle.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] din0, din1, din2, din3;
  logic [7:0] dtab [4];

  logic [3:0] t_req   [3];
  logic       t_rdy   [3];
  logic       o_vld   [3];
  logic [7:0] o_data  [3];
  logic [1:0] o_sel   [3];
  logic [3:0] o_grant [3];
  logic [3:0] o_ack   [3];
  logic       o_busy  [3];

  typedef struct {
    int         d;
    logic [19:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux4_rr_arbiter #(.WIDTH(8), .BURST(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (t_req[g]),
      .din0      (din0),
      .din1      (din1),
      .din2      (din2),
      .din3      (din3),
      .out_ready (t_rdy[g]),
      .out_valid (o_vld[g]),
      .out_data  (o_data[g]),
      .sel       (o_sel[g]),
      .grant     (o_grant[g]),
      .ack       (o_ack[g]),
      .busy      (o_busy[g])
    );
  end

  task automatic push(input int d, input logic [3:0] g, input logic [1:0] s, input logic [3:0] a,
                      input logic v, input logic b, input string tag);
    exp_t e;
    e.d   = d;
    e.v   = {g, s, a, v, b, dtab[s]};
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [19:0] obs;
    e   = q.pop_front();
    obs = {o_grant[e.d], o_sel[e.d], o_ack[e.d], o_vld[e.d], o_busy[e.d], o_data[e.d]};
    n_assert++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s: got {grant,sel,ack,vld,busy,data}=%h expected %h", e.tag, obs, e.v);
    end
  endtask

  // Drive at posedge+1, check at the following negedge.
  task automatic step(input int d, input logic [3:0] rq, input logic rdy,
                      input logic [3:0] g, input logic [1:0] s, input logic [3:0] a,
                      input logic v, input logic b, input string tag);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    t_req[d] = rq;
    t_rdy[d] = rdy;
    push(d, g, s, a, v, b, tag);
    @(negedge clk);
    pop_check();
  endtask

  logic [3:0] oh;

  initial begin
    rst  = 1'b1;
    din0 = 8'h10; din1 = 8'hA5; din2 = 8'h32; din3 = 8'h4C;
    dtab[0] = din0; dtab[1] = din1; dtab[2] = din2; dtab[3] = din3;
    for (int i = 0; i < 3; i++) begin
      t_req[i] = 4'b0000;
      t_rdy[i] = 1'b0;
    end

    // 1: BURST=1, req 0101 alternates 0/2 every beat
    step(0, 4'b0101, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "t1_reset_idle");
    step(0, 4'b0101, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1, 1'b1, "t1_beat0");
    step(0, 4'b0101, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b1, 1'b1, "t1_beat1");
    step(0, 4'b0101, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1, 1'b1, "t1_beat2");
    step(0, 4'b0101, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b1, 1'b1, "t1_beat3");
    step(0, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1, "t1_withdraw");
    step(0, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "t1_idle");

    // 2: backpressure on requester 1
    step(0, 4'b0010, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "t2_req_seen");
    for (int i = 0; i < 3; i++)
      step(0, 4'b0010, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b1, "t2_stall");
    step(0, 4'b0010, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b1, 1'b1, "t2_ready_ack");
    step(0, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b1, "t2_regrant_drop");
    step(0, 4'b0000, 1'b0, 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b0, "t2_idle");

    // 3: BURST=2, all requesting: pairs of beats rotate 0,1,2,3,0
    step(1, 4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "t3_idle");
    for (int i = 0; i < 9; i++) begin
      oh = 4'b0001 << ((i / 2) % 4);
      step(1, 4'b1111, 1'b1, oh, 2'((i / 2) % 4), oh, 1'b1, 1'b1, "t3_burst_beat");
    end
    step(1, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1, "t3_mid_burst_drop");
    step(1, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "t3_idle_end");

    // 4: granted requester 2 withdraws while 3 waits
    step(0, 4'b0100, 1'b0, 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b0, "t4_idle");
    step(0, 4'b0100, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b1, "t4_grant2");
    step(0, 4'b1100, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b1, "t4_no_preempt");
    step(0, 4'b1000, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b1, "t4_withdraw_noack");
    step(0, 4'b1000, 1'b0, 4'b1000, 2'd3, 4'b0000, 1'b1, 1'b1, "t4_grant3");

    // 5: async reset while granted and ready
    @(posedge clk);
    #3;
    t_rdy[0] = 1'b1;
    rst      = 1'b1;
    #1;
    push(0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "t5_async_reset");
    pop_check();
    step(0, 4'b1000, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "t5_release_idle");
    step(0, 4'b1000, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b1, 1'b1, "t5_grant3");
    step(0, 4'b0000, 1'b1, 4'b1000, 2'd3, 4'b0000, 1'b0, 1'b1, "t5_drop");

    // 6: BURST=3, single requester streams with no gap
    step(2, 4'b0001, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, "t6_idle");
    for (int i = 0; i < 7; i++) begin
      step(2, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1, 1'b1, "t6_stream");
      n_assert++;
      assert (g_dut[2].u_dut.r_beat_cnt === 4'(i % 3)) else begin
        n_fail++;
        $error("FAIL t6_beat_cnt: got %0d expected %0d", g_dut[2].u_dut.r_beat_cnt, i % 3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
